code_sink: RTL and testbench
============================

# code_sink

Receiving end of the `code` generator's output interface. Samples one of the generator's two 64-bit result words each enabled cycle, buffers the words in a small synchronous FIFO, and offers them to a downstream reader through a registered pop interface. Keeps a running XOR checksum and an accepted-word count so benches and top-level logic can check a stream against the expected sequence without storing it.

## Interface

Parameters:
- `WIDTH`, 64, data word width; matches the generator outputs.
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `CNT_W`, 32, width of the accepted-word counter.

Ports:
- `Clk`  in  1  single clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `En`  in  1  capture enable; same meaning as the generator's `En`.
- `Slt`  in  1  channel select: 0 captures `Input0`, 1 captures `Input1`.
- `Input0`  in  WIDTH  generator channel 0 word (`Output0` of `code`).
- `Input1`  in  WIDTH  generator channel 1 word (`Output1` of `code`).
- `Rd`  in  1  pop request from the downstream reader.
- `Dout`  out  WIDTH  popped word, registered.
- `Dout_valid`  out  1  one-cycle pulse; `Dout` is valid in the same cycle.
- `Empty`  out  1  FIFO holds no words.
- `Full`  out  1  FIFO holds DEPTH words.
- `Count`  out  $clog2(DEPTH)+1  current occupancy.
- `Overflow`  out  1  sticky; a capture was dropped.
- `Checksum`  out  WIDTH  XOR of every word written into the FIFO since reset.
- `Accepted`  out  CNT_W  number of words written into the FIFO since reset.

## Operation

- Write: `wr = En & (~Full | rd_ok)`, where `rd_ok = Rd & ~Empty`. Word written = `Slt ? Input1 : Input0`, sampled on the same edge.
- Read: `rd_ok` pops the head entry. `Dout` takes the entry on that edge, and `Dout_valid` is high for the following cycle only. `Rd` while `Empty` is ignored: no pop, and `Dout` and `Dout_valid=0` are unchanged.
- No fall-through: a word written in cycle N cannot be popped before cycle N+1, even when `Rd` is high while `Empty`.
- Full with simultaneous `En` and `Rd`: the pop and the write both occur, and `Count` stays at DEPTH.
- Full, `En=1`, and no valid read: the word is dropped. `Overflow` is set and holds until `Reset`. `Checksum` and `Accepted` are not updated.
- Each `wr` applies `Checksum <= Checksum ^ word` and `Accepted <= Accepted + 1`. `Accepted` wraps modulo 2^CNT_W.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. `Count` is updated as +1 on write only, -1 on read only, and unchanged on both or neither.
- `Empty = (Count==0)` and `Full = (Count==DEPTH)`; both are combinational from the `Count` register.
- Reset:
  - Pointers, `Count`, `Dout`, `Checksum` and `Accepted` go to 0; `Dout_valid` and `Overflow` go to 0.
  - Resulting flags: `Empty=1`, `Full=0`.
  - Buffer contents need not be cleared.
  - Reset during a stream discards all buffered words. `En`, `Rd` and the data inputs are ignored in any cycle where `Reset=1`.

## Timing

- Write latency: a word written on edge N is reflected in `Count`, `Empty`, `Checksum` and `Accepted` after edge N.
- Read latency: with `Rd` high in cycle N and `Empty=0`, `Dout` and `Dout_valid` are valid in cycle N+1.
- Minimum path from capture to `Dout`: 2 cycles (write at edge N, pop at edge N+1, visible after N+1).
- Sustained throughput: one capture and one pop per cycle.
- No combinational path from `Rd`, `En` or the data inputs to any output.

## Test plan

- Reset, then idle: `Empty=1`, `Full=0`, `Count=0`, `Checksum=0`, `Accepted=0`, `Overflow=0`, `Dout_valid=0`.
- `Slt=0`, `En=1` for 3 cycles with `Input0`=1,2,3, then `Rd=1` for 3 cycles: `Dout`=1,2,3 on consecutive `Dout_valid` pulses; `Checksum=0`, `Accepted=3`, `Empty=1`.
- `Slt=1`, `Input1=64'hFFFF_FFFF_FFFF_FFFF`, `Input0=0`, one capture: `Checksum` is all ones, and the popped `Dout` equals `Input1`.
- Fill 8 words, then 2 more captures with `Rd=0`: `Full=1`, `Overflow=1`, `Accepted=8`. Draining returns the first 8 words in order.
- At `Full`, hold `En=1` and `Rd=1` for 20 cycles: `Count` stays 8, no overflow, `Accepted` increases by 20, FIFO order is preserved across pointer wrap.
- `Rd=1` while `Empty` with `En=1`: no `Dout_valid` that cycle, a pulse the next cycle. Assert `Reset` mid-stream with 5 words buffered: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/code_sink.sv
// Receiving end of the code generator: captures one of two channel words per
// enabled cycle into a small FIFO with a registered pop port, XOR checksum and word count.
module code_sink #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       En,
  input  logic                       Slt,
  input  logic [WIDTH-1:0]           Input0,
  input  logic [WIDTH-1:0]           Input1,
  input  logic                       Rd,
  output logic [WIDTH-1:0]           Dout,
  output logic                       Dout_valid,
  output logic                       Empty,
  output logic                       Full,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow,
  output logic [WIDTH-1:0]           Checksum,
  output logic [CNT_W-1:0]           Accepted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] cks_q, cks_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  logic             empty, full, rd_ok, wr;
  logic [WIDTH-1:0] wdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  always_comb begin
    rd_ok   = Rd & ~empty;
    wr      = En & (~full | rd_ok);
    wdata   = Slt ? Input1 : Input0;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    ovf_d   = ovf_q;
    cks_d   = cks_q;
    acc_d   = acc_q;

    if (rd_ok) begin
      dout_d = mem_q[rptr_q];
      dv_d   = 1'b1;
      rptr_d = rptr_q + AW'(1);
    end
    if (wr) begin
      wptr_d = wptr_q + AW'(1);
      cks_d  = cks_q ^ wdata;
      acc_d  = acc_q + CNT_W'(1);
    end else if (En) begin
      ovf_d = 1'b1;
    end

    case ({wr, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cks_q   <= '0;
      acc_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      cks_q   <= cks_d;
      acc_q   <= acc_d;
    end
  end

  // When full, read and write hit the same slot; the read sees the old word.
  always_ff @(posedge Clk) begin
    if (wr && !Reset) mem_q[wptr_q] <= wdata;
  end

  assign Dout       = dout_q;
  assign Dout_valid = dv_q;
  assign Empty      = empty;
  assign Full       = full;
  assign Count      = count_q;
  assign Overflow   = ovf_q;
  assign Checksum   = cks_q;
  assign Accepted   = acc_q;

endmodule

// File: tb/tb_code_sink.sv
// Self-checking bench for code_sink: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_code_sink;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              reset, en, slt, rd;
  logic [WIDTH-1:0]  in0, in1;
  logic [WIDTH-1:0]  dout, checksum;
  logic              dout_valid, empty, full, overflow;
  logic [3:0]        count;
  logic [CNT_W-1:0]  accepted;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // reference model state
  logic [WIDTH-1:0]  mq[$];
  logic [WIDTH-1:0]  m_dout;
  logic              m_dv, m_ovf;
  logic [WIDTH-1:0]  m_cks;
  logic [CNT_W-1:0]  m_acc;

  code_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(reset), .En(en), .Slt(slt),
    .Input0(in0), .Input1(in1), .Rd(rd),
    .Dout(dout), .Dout_valid(dout_valid), .Empty(empty), .Full(full),
    .Count(count), .Overflow(overflow), .Checksum(checksum), .Accepted(accepted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge();
    bit rd_ok, wr;
    logic [WIDTH-1:0] w;
    if (reset) begin
      mq.delete(); m_dout = '0; m_dv = 0; m_ovf = 0; m_cks = '0; m_acc = '0;
      return;
    end
    rd_ok = rd && (mq.size() > 0);
    wr    = en && ((mq.size() < DEPTH) || rd_ok);
    w     = slt ? in1 : in0;
    m_dv  = rd_ok;
    if (rd_ok) m_dout = mq.pop_front();
    if (wr) begin
      mq.push_back(w);
      m_cks = m_cks ^ w;
      m_acc = m_acc + 1;
    end else if (en) m_ovf = 1;
  endtask

  // one clock: inputs already driven, sample 1 time unit after the edge
  task automatic step(input logic e, input logic s, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic r);
    en = e; slt = s; in0 = a; in1 = b; rd = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    step(1'b1, 1'b0, 64'h1234, 64'h5678, 1'b1);
    reset = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".empty"}, 64'(empty), 64'(mq.size() == 0));
    chk({tag, ".full"},  64'(full),  64'(mq.size() == DEPTH));
    chk({tag, ".dv"},    64'(dout_valid), 64'(m_dv));
    chk({tag, ".dout"},  dout, m_dout);
    chk({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
    chk({tag, ".cks"},   checksum, m_cks);
    chk({tag, ".acc"},   64'(accepted), 64'(m_acc));
  endtask

  typedef struct {
    logic en, slt, rd;
    logic [WIDTH-1:0] i0, i1;
    int unsigned cnt;
    logic dv;
    logic [WIDTH-1:0] dout;
    logic [CNT_W-1:0] acc;
    logic [WIDTH-1:0] cks;
  } vec_t;

  vec_t vecs[11];
  logic [WIDTH-1:0] words[$];
  logic [WIDTH-1:0] ones;

  initial begin
    ones = '1;
    vecs[0]  = '{1,0,0, 64'd1, 64'hAAAA, 1, 0, 64'd0, 1, 64'd1};
    vecs[1]  = '{1,0,0, 64'd2, 64'hBBBB, 2, 0, 64'd0, 2, 64'd3};
    vecs[2]  = '{1,0,0, 64'd3, 64'hCCCC, 3, 0, 64'd0, 3, 64'd0};
    vecs[3]  = '{0,0,1, 64'd9, 64'd9,    2, 1, 64'd1, 3, 64'd0};
    vecs[4]  = '{0,0,1, 64'd9, 64'd9,    1, 1, 64'd2, 3, 64'd0};
    vecs[5]  = '{0,0,1, 64'd9, 64'd9,    0, 1, 64'd3, 3, 64'd0};
    vecs[6]  = '{0,0,1, 64'd9, 64'd9,    0, 0, 64'd3, 3, 64'd0};
    vecs[7]  = '{1,1,0, 64'd0, ones,     1, 0, 64'd3, 4, ones};
    vecs[8]  = '{0,0,1, 64'd0, 64'd0,    0, 1, ones,  4, ones};
    vecs[9]  = '{1,0,1, 64'd5, 64'd7,    1, 0, ones,  5, ones ^ 64'd5};
    vecs[10] = '{0,0,1, 64'd0, 64'd0,    0, 1, 64'd5, 5, ones ^ 64'd5};

    reset = 0; en = 0; slt = 0; rd = 0; in0 = '0; in1 = '0;
    @(negedge clk);
    do_reset();
    step(0, 0, '0, '0, 0);
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.full",  64'(full),  64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.cks",   checksum, 64'd0);
    chk("rst.acc",   64'(accepted), 64'd0);
    chk("rst.ovf",   64'(overflow), 64'd0);
    chk("rst.dv",    64'(dout_valid), 64'd0);

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].en, vecs[i].slt, vecs[i].i0, vecs[i].i1, vecs[i].rd);
      chk($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d.empty", i), 64'(empty), 64'(vecs[i].cnt == 0));
      chk($sformatf("vec%0d.dv", i),    64'(dout_valid), 64'(vecs[i].dv));
      chk($sformatf("vec%0d.dout", i),  dout, vecs[i].dout);
      chk($sformatf("vec%0d.acc", i),   64'(accepted), 64'(vecs[i].acc));
      chk($sformatf("vec%0d.cks", i),   checksum, vecs[i].cks);
    end

    // fill, overflow, drain in order
    do_reset();
    words.delete();
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] w;
      w = {$urandom, $urandom};
      if (i < 8) words.push_back(w);
      step(1, 0, w, ~w, 0);
    end
    chk("ovf.full", 64'(full), 64'd1);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.acc",  64'(accepted), 64'd8);
    chk("ovf.count", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, '0, 1);
      chk($sformatf("drain%0d.dv", i), 64'(dout_valid), 64'd1);
      chk($sformatf("drain%0d.dout", i), dout, words[i]);
    end
    chk("drain.empty", 64'(empty), 64'd1);
    chk("drain.ovf_sticky", 64'(overflow), 64'd1);

    // full with simultaneous write and read across pointer wrap
    do_reset();
    words.delete();
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] w;
      w = {$urandom, $urandom};
      words.push_back(w);
      step(1, 1, ~w, w, 0);
    end
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] w, e;
      w = {$urandom, $urandom};
      e = words.pop_front();
      words.push_back(w);
      step(1, 0, w, ~w, 1);
      chk($sformatf("wrap%0d.count", i), 64'(count), 64'd8);
      chk($sformatf("wrap%0d.dout", i), dout, e);
    end
    chk("wrap.ovf", 64'(overflow), 64'd0);
    chk("wrap.acc", 64'(accepted), 64'd28);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, '0, 1);
      chk($sformatf("wrapdrain%0d", i), dout, words[i]);
    end

    // no fall-through: Rd while empty with En
    step(1, 0, 64'h77, 64'h0, 1);
    chk("nft.dv0", 64'(dout_valid), 64'd0);
    step(0, 0, '0, '0, 1);
    chk("nft.dv1", 64'(dout_valid), 64'd1);
    chk("nft.dout", dout, 64'h77);

    // reset mid-stream with 5 words buffered and overflow set
    for (int i = 0; i < 9; i++) step(1, 0, 64'(i + 100), '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 1);
    chk("mid.count", 64'(count), 64'd5);
    do_reset();
    chk("mid.rst.count", 64'(count), 64'd0);
    chk("mid.rst.empty", 64'(empty), 64'd1);
    chk("mid.rst.full",  64'(full),  64'd0);
    chk("mid.rst.dout",  dout, 64'd0);
    chk("mid.rst.dv",    64'(dout_valid), 64'd0);
    chk("mid.rst.ovf",   64'(overflow), 64'd0);
    chk("mid.rst.cks",   checksum, 64'd0);
    chk("mid.rst.acc",   64'(accepted), 64'd0);
    step(0, 0, '0, '0, 1);
    chk("mid.post.dv", 64'(dout_valid), 64'd0);

    // randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step(1'($urandom_range(0, 99) < 60), 1'($urandom), {$urandom, $urandom},
           {$urandom, $urandom}, 1'($urandom_range(0, 99) < 45));
      reset = 0;
      chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
